// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the PCS RX asynchronous 66-bit block FIFO.
// Synchronizes the write-domain Gray pointer, owns the read pointer and the
// empty flag, reports a conservative fill level and presents memory words
// through a registered valid/ready output stage.
module fifo_rd_ctrl #(
  parameter int unsigned DATASIZE = 66,
  parameter int unsigned ADDRSIZE = 3
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  // Pointer width: one extra MSB distinguishes full from empty.
  localparam int PW = ADDRSIZE + 1;

  // Convert a Gray-coded pointer to binary (prefix XOR from the MSB down).
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int k = 1; k < PW; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  // Synchronizer flops; nothing else may look at wptr.
  logic [PW-1:0]       r_rq1_wptr;
  logic [PW-1:0]       r_rq2_wptr;

  // Read pointer state.
  logic [PW-1:0]       r_rbin;
  logic [PW-1:0]       r_rptr;
  logic                r_rempty;
  logic [PW-1:0]       r_rlevel;

  // Output stage.
  logic [DATASIZE-1:0] r_dout;
  logic                r_dout_valid;

  // Combinational next-state terms.
  logic                w_pop;
  logic                w_accept;
  logic [PW-1:0]       w_rbinnext;
  logic [PW-1:0]       w_rgraynext;
  logic [PW-1:0]       w_wbin;
  logic [PW-1:0]       w_level_next;

  // Pop when memory holds data and the output register is free or draining.
  always_comb begin
    w_accept     = r_dout_valid & dout_ready;
    w_pop        = ~r_rempty & (~r_dout_valid | dout_ready);
    w_rbinnext   = r_rbin + PW'(w_pop);
    w_rgraynext  = (w_rbinnext >> 1) ^ w_rbinnext;
    // Level uses the synchronized (stale) write pointer so it never over-reports.
    w_wbin       = gray2bin(r_rq2_wptr);
    w_level_next = w_wbin - w_rbinnext;
  end

  // Two-flop synchronizer for the incoming Gray write pointer.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rq1_wptr <= '0;
      r_rq2_wptr <= '0;
    end else begin
      r_rq1_wptr <= wptr;
      r_rq2_wptr <= r_rq1_wptr;
    end
  end

  // Read pointer (binary and Gray), empty flag and fill level.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
      r_rlevel <= '0;
    end else begin
      r_rbin   <= w_rbinnext;
      r_rptr   <= w_rgraynext;
      // Exact Gray equality including the MSB; a stale write pointer keeps it set.
      r_rempty <= (w_rgraynext == r_rq2_wptr);
      r_rlevel <= w_level_next;
    end
  end

  // Registered output stage; dout only changes on a pop, so it is frozen
  // while valid is held against a deasserted ready.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_pop) begin
      r_dout       <= rdata_mem;
      r_dout_valid <= 1'b1;
    end else if (w_accept) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign raddr      = r_rbin[ADDRSIZE-1:0];
  assign rptr       = r_rptr;
  assign rempty     = r_rempty;
  assign rlevel     = r_rlevel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
